// File: rtl/bcd_convert_seq.sv
// rtl/bcd_convert_seq.sv - sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional two's-complement input handling is enabled with BCD_CONVERT_SIGNED_EN.
module bcd_convert_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  neg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   work;
  logic [BCD_W-1:0]   adj;
  logic [BIN_W-1:0]   opnd;
  logic [BIN_W-1:0]   load_val;
  logic               sticky;

  // Per-digit add-3 correction; digits never carry into each other here.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

`ifdef BCD_CONVERT_SIGNED_EN
  logic neg_stage;
  logic neg_q;

  // Magnitude is taken as BIN_W-bit unsigned, so the most negative value maps to 2**(BIN_W-1).
  assign load_val = bin[BIN_W-1] ? (~bin + {{(BIN_W-1){1'b0}}, 1'b1}) : bin;
  assign neg      = neg_q;
`else
  assign load_val = bin;
  assign neg      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      opnd     <= '0;
      sticky   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
`ifdef BCD_CONVERT_SIGNED_EN
      neg_stage <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opnd   <= load_val;
            work   <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef BCD_CONVERT_SIGNED_EN
            neg_stage <= bin[BIN_W-1];
`endif
          end
        end
        SHIFT: begin
          // {digits, operand} shifts as one register; the bit leaving the top digit marks overflow.
          work   <= {adj[BCD_W-2:0], opnd[BIN_W-1]};
          opnd   <= {opnd[BIN_W-2:0], 1'b0};
          sticky <= sticky | adj[BCD_W-1];
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          bcd      <= work;
          overflow <= sticky;
          done     <= 1'b1;
`ifdef BCD_CONVERT_SIGNED_EN
          neg_q <= neg_stage;
`endif
          if (start) begin
            opnd   <= load_val;
            work   <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef BCD_CONVERT_SIGNED_EN
            neg_stage <= bin[BIN_W-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb/tb_bcd_convert_seq.sv - self-checking bench for bcd_convert_seq (default and 4-digit instances).
// Expectations follow BCD_CONVERT_SIGNED_EN when it is defined.
module tb_bcd_convert_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [31:0] bin0, bin1;
  logic        busy0, busy1, done0, done1;
  logic [39:0] bcd0;
  logic [15:0] bcd1;
  logic        ovf0, ovf1, neg0, neg1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_convert_seq #(.BIN_W(32), .DIGITS(10), .CNT_W(6)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bin(bin0), .busy(busy0),
    .done(done0), .bcd(bcd0), .overflow(ovf0), .neg(neg0)
  );

  bcd_convert_seq #(.BIN_W(32), .DIGITS(4), .CNT_W(6)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bin(bin1), .busy(busy1),
    .done(done1), .bcd(bcd1), .overflow(ovf1), .neg(neg1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division of the operand's value.
  function automatic void model(input logic [31:0] v, input int digits,
                                output logic [39:0] eb, output logic eo, output logic en);
    longint unsigned mag;
    mag = 64'(v);
    en  = 1'b0;
`ifdef BCD_CONVERT_SIGNED_EN
    if (v[31]) begin
      mag = 64'h1_0000_0000 - 64'(v);
      en  = 1'b1;
    end
`endif
    eb = '0;
    for (int i = 0; i < digits; i++) begin
      eb[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    eo = (mag != 0);
  endfunction

  task automatic wait_done(input int which, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (((which == 0) ? done0 : done1) !== 1'b1 && lat < 40) begin
      if (((which == 0) ? busy0 : busy1) === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_conv(input int which, input logic [31:0] v, input string tag);
    logic [39:0] eb;
    logic        eo, en;
    int          lat, bcnt;
    model(v, (which == 0) ? 10 : 4, eb, eo, en);
    if (which == 0) begin start0 = 1'b1; bin0 = v; end
    else            begin start1 = 1'b1; bin1 = v; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    wait_done(which, lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_busy"}, 64'(bcnt), 64'd32);
    if (which == 0) begin
      chk({tag, "_bcd"}, 64'(bcd0), 64'(eb));
      chk({tag, "_ovf"}, 64'(ovf0), 64'(eo));
      chk({tag, "_neg"}, 64'(neg0), 64'(en));
    end else begin
      chk({tag, "_bcd"}, 64'(bcd1), 64'(eb[15:0]));
      chk({tag, "_ovf"}, 64'(ovf1), 64'(eo));
      chk({tag, "_neg"}, 64'(neg1), 64'(en));
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'((which == 0) ? done0 : done1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] eb_a, eb_b;
    logic        eo_a, eo_b, en_a, en_b;
    logic [31:0] va, vb, r;
    int          lat, bcnt, npulse;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; bin0 = '0; bin1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_bcd0",  64'(bcd0),  64'd0);
    chk("rst_ovf0",  64'(ovf0),  64'd0);
    chk("rst_neg0",  64'(neg0),  64'd0);
    chk("rst_bcd1",  64'(bcd1),  64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_conv(0, 32'd0, "zero");
    run_conv(0, 32'hFFFF_FFFF, "allones");
    run_conv(0, 32'h8000_0000, "minneg");
    run_conv(1, 32'd12345, "d4_ovf");
    run_conv(1, 32'd9999, "d4_fit");
    run_conv(1, 32'd10000, "d4_edge");

    for (int i = 0; i < 8; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      run_conv(i % 2, r, (i % 2 == 0) ? "rand10" : "rand4");
    end

    // Start held through the run with bin changing: one result for A, then B accepted in DONE.
    va = 32'd31415926;
    vb = 32'd2718;
    model(va, 10, eb_a, eo_a, en_a);
    model(vb, 10, eb_b, eo_b, en_b);
    start0 = 1'b1; bin0 = va;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    bin0 = vb;
    wait_done(0, lat, bcnt);
    chk("hold_lat", 64'(lat + 5), 64'd33);
    chk("hold_bcd", 64'(bcd0), 64'(eb_a));
    chk("b2b_busy", 64'(busy0), 64'd1);
    start0 = 1'b0;
    @(posedge clk); #1;
    wait_done(0, lat, bcnt);
    chk("b2b_lat", 64'(lat + 1), 64'd33);
    chk("b2b_bcd", 64'(bcd0), 64'(eb_b));
    @(posedge clk); #1;

    // Reset mid-run: abandon the conversion, clear outputs, no done afterwards.
    start0 = 1'b1; bin0 = 32'd987654;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy0), 64'd0);
    chk("midrst_bcd",  64'(bcd0),  64'd0);
    chk("midrst_done", 64'(done0), 64'd0);
    rst = 1'b0;
    npulse = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) npulse++;
    end
    chk("midrst_nodone", 64'(npulse), 64'd0);
    run_conv(0, 32'd255, "after_rst");
    chk("after_rst_lo", 64'(bcd0[7:0]), 64'h55);
    chk("after_rst_d2", 64'(bcd0[11:8]), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
